// File: rtl/master_start_sync.sv
// System time base with a 1 Hz-aligned preset, plus the command sequencer that loads DDS
// parameters over a REQ/ACK handshake and times blank / emission / receive intervals.
module master_start_sync (
  input  logic        clk_48,
  input  logic        reset,
  input  logic [63:0] sys_time,
  input  logic        t1hz,
  input  logic        sys_time_update,
  output logic [63:0] cur_time,
  output logic        sys_time_update_ok,
  input  logic        wr_data,
  output logic        req_command,
  input  logic [47:0] mem_dds_freq,
  input  logic [47:0] mem_dds_delta_freq,
  input  logic [31:0] mem_dds_delta_rate,
  input  logic [63:0] mem_time_start,
  input  logic [15:0] mem_n_impuls,
  input  logic [1:0]  mem_type_impulse,
  input  logic [31:0] mem_interval_ti,
  input  logic [31:0] mem_interval_tp,
  input  logic [31:0] mem_tblank1,
  input  logic [31:0] mem_tblank2,
  output logic [47:0] dds_freq,
  output logic [47:0] dds_delta_freq,
  output logic [31:0] dds_delta_rate,
  output logic        dds_start,
  output logic        req,
  input  logic        ack,
  output logic        en_iz,
  output logic        en_pr
);

  typedef enum logic [3:0] {
    IDLE = 4'd0, WAIT_CMD = 4'd1, WAIT_START = 4'd2, LOAD_DDS = 4'd3, ACK_LOW = 4'd4,
    BLANK1 = 4'd5, IZ = 4'd6, BLANK2 = 4'd7, PR = 4'd8, DONE = 4'd9
  } state_t;

  state_t      state_r, state_next;
  logic [63:0] time_r;
  logic        t1hz_d_r, ok_r, ack_s1_r, ack_s2_r, coh_r;
  logic [31:0] cnt_r, cnt_next;
  logic [15:0] imp_r, imp_next;
  logic [47:0] freq_r, dfreq_r, dds_freq_r, dds_dfreq_r;
  logic [31:0] drate_r, dds_drate_r, ti_r, tp_r, tb1_r, tb2_r;
  logic [63:0] start_r;
  logic [15:0] n_r;
  logic [1:0]  type_r;
  logic        req_command_r, req_r, en_iz_r, en_pr_r, dds_start_r;
  logic        latch_s, seek_s;
  logic [2:0]  from_s, phase_s, rep_s;

  // Phases are numbered 1..4 (BLANK1, IZ, BLANK2, PR); returns the first non-empty one at or after 'from', 0 if none.
  function automatic logic [2:0] first_phase(input logic [2:0] from, input logic [31:0] d1, d2, d3, d4);
    if (from <= 3'd1 && d1 != 32'd0)      first_phase = 3'd1;
    else if (from <= 3'd2 && d2 != 32'd0) first_phase = 3'd2;
    else if (from <= 3'd3 && d3 != 32'd0) first_phase = 3'd3;
    else if (from <= 3'd4 && d4 != 32'd0) first_phase = 3'd4;
    else                                  first_phase = 3'd0;
  endfunction

  function automatic state_t phase_state(input logic [2:0] idx);
    case (idx)
      3'd1:    phase_state = BLANK1;
      3'd2:    phase_state = IZ;
      3'd3:    phase_state = BLANK2;
      3'd4:    phase_state = PR;
      default: phase_state = DONE;
    endcase
  endfunction

  function automatic logic [31:0] phase_len(input logic [2:0] idx, input logic [31:0] d1, d2, d3, d4);
    case (idx)
      3'd1:    phase_len = d1 - 32'd1;
      3'd2:    phase_len = d2 - 32'd1;
      3'd3:    phase_len = d3 - 32'd1;
      3'd4:    phase_len = d4 - 32'd1;
      default: phase_len = 32'd0;
    endcase
  endfunction

  // Free-running time with a preset applied on the T1hz rising edge when armed
  always_ff @(posedge clk_48) begin
    if (reset) begin
      time_r   <= 64'd0;
      t1hz_d_r <= 1'b0;
      ok_r     <= 1'b0;
    end else begin
      t1hz_d_r <= t1hz;
      if (t1hz && !t1hz_d_r && sys_time_update) begin
        time_r <= sys_time;
        ok_r   <= 1'b1;
      end else begin
        time_r <= time_r + 64'd1;
        ok_r   <= 1'b0;
      end
    end
  end

  // Two-flop synchronizer for the ACK coming from the DDS clock domain
  always_ff @(posedge clk_48) begin
    if (reset) begin
      ack_s1_r <= 1'b0;
      ack_s2_r <= 1'b0;
    end else begin
      ack_s1_r <= ack;
      ack_s2_r <= ack_s1_r;
    end
  end

  // Next-state logic; phase counters hold (length - 1) and the phase ends when they reach zero
  always_comb begin
    state_next = state_r;
    cnt_next   = cnt_r;
    imp_next   = imp_r;
    latch_s    = 1'b0;
    seek_s     = 1'b0;
    from_s     = 3'd1;
    phase_s    = 3'd0;
    rep_s      = first_phase(3'd1, tb1_r, ti_r, tb2_r, tp_r);
    case (state_r)
      IDLE:     state_next = WAIT_CMD;
      WAIT_CMD: begin
        if (wr_data) begin
          state_next = WAIT_START;
          latch_s    = 1'b1;
          imp_next   = 16'd0;
        end else begin
          state_next = WAIT_CMD;
        end
      end
      WAIT_START: begin
        if (time_r >= start_r) state_next = (n_r == 16'd0) ? DONE : LOAD_DDS;
        else                   state_next = WAIT_START;
      end
      LOAD_DDS: begin
        if (ack_s2_r) state_next = ACK_LOW;
        else          state_next = LOAD_DDS;
      end
      ACK_LOW: begin
        if (!ack_s2_r) seek_s = 1'b1;
        else           state_next = ACK_LOW;
      end
      BLANK1, IZ, BLANK2, PR: begin
        if (cnt_r == 32'd0) begin
          seek_s = 1'b1;
          case (state_r)
            BLANK1:  from_s = 3'd2;
            IZ:      from_s = 3'd3;
            BLANK2:  from_s = 3'd4;
            default: from_s = 3'd5;
          endcase
        end else begin
          cnt_next = cnt_r - 32'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase

    if (seek_s) begin
      phase_s = first_phase(from_s, tb1_r, ti_r, tb2_r, tp_r);
      if (phase_s != 3'd0) begin
        state_next = phase_state(phase_s);
        cnt_next   = phase_len(phase_s, tb1_r, ti_r, tb2_r, tp_r);
      end else begin
        imp_next = imp_r + 16'd1;
        if (({1'b0, imp_r} + 17'd1) < {1'b0, n_r}) begin
          if (type_r == 2'd0) begin
            state_next = LOAD_DDS;
          end else if (rep_s != 3'd0) begin
            state_next = phase_state(rep_s);
            cnt_next   = phase_len(rep_s, tb1_r, ti_r, tb2_r, tp_r);
          end else begin
            // every interval is empty: remaining coherent impulses take no time
            state_next = DONE;
          end
        end else begin
          state_next = DONE;
        end
      end
    end else begin
      phase_s = 3'd0;
    end
  end

  // State, phase counter and impulse counter
  always_ff @(posedge clk_48) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 32'd0;
      imp_r   <= 16'd0;
    end else begin
      state_r <= state_next;
      cnt_r   <= cnt_next;
      imp_r   <= imp_next;
    end
  end

  // Command latch
  always_ff @(posedge clk_48) begin
    if (reset) begin
      freq_r <= 48'd0; dfreq_r <= 48'd0; drate_r <= 32'd0; start_r <= 64'd0; n_r <= 16'd0;
      type_r <= 2'd0;  ti_r    <= 32'd0; tp_r    <= 32'd0; tb1_r   <= 32'd0; tb2_r <= 32'd0;
    end else if (latch_s) begin
      freq_r <= mem_dds_freq;     dfreq_r <= mem_dds_delta_freq; drate_r <= mem_dds_delta_rate;
      start_r <= mem_time_start;  n_r     <= mem_n_impuls;       type_r  <= mem_type_impulse;
      ti_r   <= mem_interval_ti;  tp_r    <= mem_interval_tp;
      tb1_r  <= mem_tblank1;      tb2_r   <= mem_tblank2;
    end
  end

  // Outputs registered from the next state so they line up exactly with the state register
  always_ff @(posedge clk_48) begin
    if (reset) begin
      req_command_r <= 1'b0; req_r <= 1'b0; en_iz_r <= 1'b0; en_pr_r <= 1'b0;
      dds_start_r   <= 1'b0; coh_r <= 1'b0;
      dds_freq_r    <= 48'd0; dds_dfreq_r <= 48'd0; dds_drate_r <= 32'd0;
    end else begin
      req_command_r <= (state_r == IDLE);
      req_r         <= (state_next == LOAD_DDS);
      en_iz_r       <= (state_next == IZ);
      en_pr_r       <= (state_next == PR);
      if (state_next == IZ)        coh_r <= 1'b1;
      else if (state_next == DONE) coh_r <= 1'b0;
      dds_start_r <= (state_next == IZ) ||
                     ((type_r != 2'd0) && coh_r && (state_next != DONE));
      if (state_next == LOAD_DDS && state_r != LOAD_DDS) begin
        dds_freq_r  <= freq_r;
        dds_dfreq_r <= dfreq_r;
        dds_drate_r <= drate_r;
      end
    end
  end

  assign cur_time           = time_r;
  assign sys_time_update_ok = ok_r;
  assign req_command        = req_command_r;
  assign req                = req_r;
  assign en_iz              = en_iz_r;
  assign en_pr              = en_pr_r;
  assign dds_start          = dds_start_r;
  assign dds_freq           = dds_freq_r;
  assign dds_delta_freq     = dds_dfreq_r;
  assign dds_delta_rate     = dds_drate_r;

endmodule

// File: tb/tb_master_start_sync.sv
// Directed bench for master_start_sync: time preset, pulse packs in both modes,
// degenerate commands and a mid-pack reset, with an ACK echo model on the handshake.
`timescale 1ns/1ps
module tb_master_start_sync;

  logic        clk_48 = 1'b0;
  logic        reset, t1hz, sys_time_update, wr_data, ack;
  logic [63:0] sys_time, cur_time, mem_time_start;
  logic        sys_time_update_ok, req_command, dds_start, req, en_iz, en_pr;
  logic [47:0] mem_dds_freq, mem_dds_delta_freq, dds_freq, dds_delta_freq;
  logic [31:0] mem_dds_delta_rate, mem_interval_ti, mem_interval_tp, mem_tblank1, mem_tblank2;
  logic [31:0] dds_delta_rate;
  logic [15:0] mem_n_impuls;
  logic [1:0]  mem_type_impulse;

  int n_checks = 0, n_pass = 0;
  int cyc = 0, wr_cyc = 0, first_req_cyc = 0, last_fall = 0;
  int n_req_rise, n_ds_rise, n_ds_high, n_ds_ne, n_iz, n_pr;
  logic [63:0] first_req_time;
  logic req_q = 1'b0, ds_q = 1'b0, iz_q = 1'b0, seg_on = 1'b0;
  logic [2:0] ack_pipe = 3'd0;
  int seg_code[$], seg_len[$], iz_delay[$];

  always #10.4 clk_48 = ~clk_48;

  master_start_sync dut (
    .clk_48(clk_48), .reset(reset), .sys_time(sys_time), .t1hz(t1hz),
    .sys_time_update(sys_time_update), .cur_time(cur_time), .sys_time_update_ok(sys_time_update_ok),
    .wr_data(wr_data), .req_command(req_command),
    .mem_dds_freq(mem_dds_freq), .mem_dds_delta_freq(mem_dds_delta_freq),
    .mem_dds_delta_rate(mem_dds_delta_rate), .mem_time_start(mem_time_start),
    .mem_n_impuls(mem_n_impuls), .mem_type_impulse(mem_type_impulse),
    .mem_interval_ti(mem_interval_ti), .mem_interval_tp(mem_interval_tp),
    .mem_tblank1(mem_tblank1), .mem_tblank2(mem_tblank2),
    .dds_freq(dds_freq), .dds_delta_freq(dds_delta_freq), .dds_delta_rate(dds_delta_rate),
    .dds_start(dds_start), .req(req), .ack(ack), .en_iz(en_iz), .en_pr(en_pr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // One clock: sample on the falling edge, update pack statistics, then echo REQ back as ACK
  task automatic step();
    int code;
    @(negedge clk_48);
    cyc++;
    if (req && !req_q) begin
      n_req_rise++;
      if (n_req_rise == 1) begin
        first_req_cyc  = cyc;
        first_req_time = cur_time;
      end
    end
    if (!req && req_q) last_fall = cyc;
    if (dds_start && !ds_q) n_ds_rise++;
    if (dds_start) n_ds_high++;
    if (dds_start != en_iz) n_ds_ne++;
    if (en_iz) n_iz++;
    if (en_pr) n_pr++;
    if (en_iz && !iz_q) begin
      iz_delay.push_back(cyc - last_fall);
      seg_on = 1'b1;
    end
    code = en_iz ? 2 : (en_pr ? 1 : 0);
    if (seg_on) begin
      if (seg_len.size() == 0 || seg_code[seg_code.size()-1] != code) begin
        seg_code.push_back(code);
        seg_len.push_back(1);
      end else begin
        seg_len[seg_len.size()-1] = seg_len[seg_len.size()-1] + 1;
      end
    end
    req_q = req; ds_q = dds_start; iz_q = en_iz;
    ack_pipe = {ack_pipe[1:0], req};
    ack = ack_pipe[2];
  endtask

  task automatic send_cmd(input logic [63:0] start, input logic [15:0] n, input logic [1:0] typ,
                          input logic [31:0] ti, input logic [31:0] tp, input logic [31:0] tb1,
                          input logic [31:0] tb2, input logic [47:0] freq);
    seg_code.delete(); seg_len.delete(); iz_delay.delete();
    n_req_rise = 0; n_ds_rise = 0; n_ds_high = 0; n_ds_ne = 0; n_iz = 0; n_pr = 0;
    seg_on = 1'b0; last_fall = cyc; first_req_cyc = 0; first_req_time = 64'd0;
    mem_time_start = start; mem_n_impuls = n; mem_type_impulse = typ;
    mem_interval_ti = ti; mem_interval_tp = tp; mem_tblank1 = tb1; mem_tblank2 = tb2;
    mem_dds_freq = freq; mem_dds_delta_freq = {freq[23:0], freq[47:24]};
    mem_dds_delta_rate = freq[31:0] ^ 32'hA5A5_A5A5;
    wr_data = 1'b1;
    wr_cyc = cyc;
    step();
    wr_data = 1'b0;
  endtask

  task automatic run_pack(input string tag, input int bound);
    int k;
    k = 0;
    while (req_command !== 1'b1 && k < bound) begin
      step();
      k++;
    end
    chk(tag, 64'(k < bound), 64'd1);
  endtask

  // Expected interval pattern from the first IZ: IZ, blank2, PR, gap, IZ, blank2, PR
  task automatic chk_segs(input string tag, input int gap);
    int ec[7] = '{2, 0, 1, 0, 2, 0, 1};
    int el[7] = '{6144, 384, 6144, 0, 6144, 384, 6144};
    logic [63:0] obs;
    el[3] = gap;
    for (int i = 0; i < 7; i++) begin
      obs = (i < seg_len.size()) ? {32'(seg_code[i]), 32'(seg_len[i])} : 64'hFFFF_FFFF_FFFF_FFFF;
      chk($sformatf("%s_seg%0d", tag, i), obs, {32'(ec[i]), 32'(el[i])});
    end
  endtask

  function automatic logic [63:0] iz_d(input int idx);
    return (idx < iz_delay.size()) ? 64'(iz_delay[idx]) : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  initial begin
    int k;
    reset = 1'b1; t1hz = 1'b0; sys_time_update = 1'b0; sys_time = 64'd0; wr_data = 1'b0; ack = 1'b0;
    mem_dds_freq = 48'd0; mem_dds_delta_freq = 48'd0; mem_dds_delta_rate = 32'd0;
    mem_time_start = 64'd0; mem_n_impuls = 16'd0; mem_type_impulse = 2'd0;
    mem_interval_ti = 32'd0; mem_interval_tp = 32'd0; mem_tblank1 = 32'd0; mem_tblank2 = 32'd0;
    n_req_rise = 0; n_ds_rise = 0; n_ds_high = 0; n_ds_ne = 0; n_iz = 0; n_pr = 0;
    first_req_time = 64'd0;

    repeat (3) step();
    chk("rst_time", cur_time, 64'd0);
    chk("rst_outs", 64'({req_command, req, en_iz, en_pr, dds_start, sys_time_update_ok}), 64'd0);
    chk("rst_dds", 64'(dds_freq), 64'd0);
    reset = 1'b0;
    step();
    chk("rel_reqcmd", 64'(req_command), 64'd1);
    chk("rel_time", cur_time, 64'd1);
    step();
    chk("reqcmd_one_cycle", 64'(req_command), 64'd0);
    chk("time_inc", cur_time, 64'd2);

    // preset near the top, then wrap
    sys_time = 64'hFFFF_FFFF_FFFF_FFFE; t1hz = 1'b1; sys_time_update = 1'b1;
    step();
    chk("preset_val", cur_time, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("preset_ok", 64'(sys_time_update_ok), 64'd1);
    t1hz = 1'b0; sys_time_update = 1'b0;
    step();
    chk("preset_ok_pulse", 64'(sys_time_update_ok), 64'd0);
    chk("time_max", cur_time, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    chk("time_wrap", cur_time, 64'd0);
    // edge without arming changes nothing
    sys_time = 64'd123; t1hz = 1'b1;
    step();
    chk("unarmed_time", cur_time, 64'd1);
    chk("unarmed_ok", 64'(sys_time_update_ok), 64'd0);
    t1hz = 1'b0;
    step();
    sys_time = 64'd4996; t1hz = 1'b1; sys_time_update = 1'b1;
    step();
    t1hz = 1'b0; sys_time_update = 1'b0;
    repeat (4) step();
    chk("time_5000", cur_time, 64'd5000);
    sys_time = 64'd0; t1hz = 1'b1; sys_time_update = 1'b1;
    step();
    chk("preset0_val", cur_time, 64'd0);
    chk("preset0_ok", 64'(sys_time_update_ok), 64'd1);
    t1hz = 1'b0; sys_time_update = 1'b0;
    step();
    chk("preset0_next", cur_time, 64'd1);
    chk("preset0_ok_low", 64'(sys_time_update_ok), 64'd0);

    // coherent pack, waits for TIME_START
    send_cmd(64'h12C0, 16'd2, 2'd1, 32'h1800, 32'h1800, 32'h180, 32'h180, 48'h1234_5678_9ABC);
    run_pack("p1_done", 40000);
    chk("p1_start_time", first_req_time, 64'd4801);
    chk("p1_handshakes", 64'(n_req_rise), 64'd1);
    chk("p1_blank1", iz_d(0), 64'd389);
    chk_segs("p1", 384);
    chk("p1_ds_rises", 64'(n_ds_rise), 64'd1);
    chk("p1_ds_high", 64'(n_ds_high), 64'd25728);
    chk("p1_iz_pr", {32'(n_iz), 32'(n_pr)}, {32'd12288, 32'd12288});
    chk("p1_dds", {16'd0, dds_freq}, 64'h1234_5678_9ABC);
    chk("p1_dds_df", {16'd0, dds_delta_freq}, 64'h789A_BC12_3456);
    chk("p1_dds_rate", 64'(dds_delta_rate), 64'(32'h5678_9ABC ^ 32'hA5A5_A5A5));
    chk("p1_ds_end", 64'(dds_start), 64'd0);
    step();
    chk("p1_reqcmd_pulse", 64'(req_command), 64'd0);

    // non-coherent pack, start time already passed
    send_cmd(64'h12C0, 16'd2, 2'd0, 32'h1800, 32'h1800, 32'h180, 32'h180, 48'hABCD_EF01_2345);
    run_pack("p2_done", 40000);
    chk("p2_start_lat", 64'(first_req_cyc - wr_cyc), 64'd2);
    chk("p2_handshakes", 64'(n_req_rise), 64'd2);
    chk("p2_blank1_a", iz_d(0), 64'd389);
    chk("p2_blank1_b", iz_d(1), 64'd389);
    chk_segs("p2", 394);
    chk("p2_ds_rises", 64'(n_ds_rise), 64'd2);
    chk("p2_ds_high", 64'(n_ds_high), 64'd12288);
    chk("p2_ds_eq_iz", 64'(n_ds_ne), 64'd0);
    chk("p2_dds", {16'd0, dds_freq}, 64'hABCD_EF01_2345);

    // zero impulses: straight to the next command request
    send_cmd(64'd0, 16'd0, 2'd0, 32'd5, 32'd5, 32'd5, 32'd5, 48'h0000_1111_2222);
    run_pack("p3_done", 50);
    chk("p3_lat", 64'(cyc - wr_cyc), 64'd4);
    chk("p3_no_req", 64'(n_req_rise), 64'd0);
    chk("p3_no_iz_pr", 64'(n_iz + n_pr), 64'd0);
    chk("p3_dds_hold", {16'd0, dds_freq}, 64'hABCD_EF01_2345);

    // no blank1, no receive interval
    send_cmd(64'd0, 16'd1, 2'd0, 32'd20, 32'd0, 32'd0, 32'd10, 48'h0000_0000_0042);
    run_pack("p4_done", 500);
    chk("p4_iz_after_hs", iz_d(0), 64'd5);
    chk("p4_iz_len", 64'(n_iz), 64'd20);
    chk("p4_no_pr", 64'(n_pr), 64'd0);
    chk("p4_handshakes", 64'(n_req_rise), 64'd1);

    // reset in the middle of an emission interval
    send_cmd(64'd0, 16'd1, 2'd1, 32'd1000, 32'd0, 32'd0, 32'd0, 48'h0000_0000_0077);
    k = 0;
    while (!en_iz && k < 100) begin
      step();
      k++;
    end
    chk("p5_iz_reached", 64'(k < 100), 64'd1);
    repeat (10) step();
    chk("p5_ds_in_iz", 64'(dds_start), 64'd1);
    reset = 1'b1;
    step();
    chk("p5_abort", 64'({en_iz, dds_start, req}), 64'd0);
    chk("p5_abort_time", cur_time, 64'd0);
    reset = 1'b0;
    step();
    chk("p5_reqcmd", 64'(req_command), 64'd1);
    chk("p5_iz_off", 64'(en_iz), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
